mdu: RTL and testbench
======================

# mdu

Multi-cycle multiply/divide unit for the RV64 core, implementing the M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and the W forms). It sits beside the single-cycle ALU in the execute stage. The execute stage hands it an operation over a valid/ready request port, and it returns the result over a valid/ready response port. It uses iterative radix-2 shift-add multiplication and restoring division on operand magnitudes, followed by a sign-fix step.

## Interface
- `XLEN`, default 64: datapath width; equals the `RegBus` width.
- `clk`, input, 1: core clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `valid_i_mdu`, input, 1: request valid.
- `ready_o_mdu`, output, 1: request ready; high only in IDLE.
- `mdop_i_mdu`, input, 3: opcode. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `word_i_mdu`, input, 1: W form (32-bit operation, sign-extended result). Must be 0 for MULH, MULHSU and MULHU.
- `op1_i_mdu`, input, `RegBus`: rs1 / dividend / multiplicand.
- `op2_i_mdu`, input, `RegBus`: rs2 / divisor / multiplier.
- `flush_i_mdu`, input, 1: abort any operation in flight.
- `valid_o_mdu`, output, 1: result valid.
- `ready_i_mdu`, input, 1: consumer ready.
- `result_o_mdu`, output, `RegBus`: result.

## Operation
- **States:** IDLE, CALC, FIX, DONE.
- **Request accept:** a request is accepted when `valid_i_mdu & ready_o_mdu`. Operands and opcode are captured at that edge. Inputs are ignored outside IDLE.
- **Operand preparation:**
  - W form: operands are truncated to bits [31:0]; N = 32. Otherwise N = 64.
  - Signed operand: DIV, REM, MULH (both operands), MULHSU (op1 only), MUL/MULW (sign irrelevant, treated as unsigned).
  - Each signed operand is converted to its magnitude. The result sign is recorded: quotient/product sign = sign1 ^ sign2; remainder sign = sign1.
- **CALC:** runs N cycles, driven by a counter that counts down from N-1 to 0.
  - Multiply: 2N-bit accumulator; one multiplier bit per cycle, add-then-shift.
  - Divide: one restoring step per cycle, producing an N-bit quotient and remainder.
- **FIX:** one cycle.
  - Conditionally negate the result; quotient negation is suppressed when the divisor is 0.
  - Select the result field:
    - MUL: low N bits.
    - MULH*: high N bits.
    - DIV*: quotient.
    - REM*: remainder.
  - W form: sign-extend bit 31 to 64 bits, for unsigned W ops too (DIVUW/REMUW).
- **Division special cases** (architectural results, fall out of the algorithm plus the FIX rule):
  - Divide by zero: quotient = all ones, remainder = dividend (W form: sign-extended low 32 bits).
  - Signed overflow (most-negative / -1): quotient = dividend, remainder = 0.
- **DONE:** `valid_o_mdu` = 1 and `result_o_mdu` is held stable. On `ready_i_mdu` the unit goes to IDLE at that edge. No new request is accepted in that same cycle, because `ready_o_mdu` is 0 in DONE.
- **Flush:** `flush_i_mdu` in any state → IDLE at the next edge, and any result is discarded. Flush has priority over accept and completion.
- **Reset:** sets state to IDLE and counter to 0. Outputs after reset: `ready_o_mdu` = 1, `valid_o_mdu` = 0, `result_o_mdu` = 0. Reset mid-CALC or in DONE drops the operation.

## Timing
- Accept cycle = cycle 0. CALC occupies cycles 1..N, FIX is cycle N+1, DONE starts at cycle N+2.
- Latency: 66 cycles (64-bit), 34 cycles (W form).
- Back-to-back throughput: one operation per N+3 cycles with `ready_i_mdu` held high. This counts the DONE cycle plus the IDLE cycle before the next accept.
- `valid_o_mdu` and `result_o_mdu` are registered; no combinational path from inputs to outputs.
- `ready_o_mdu` is decoded from state only.

## Configuration
- `MDU_FAST_SPECIAL_EN` defined: at accept, four cases skip CALC and FIX and go IDLE→DONE directly, giving `valid_o_mdu` in cycle 1. Results are identical to the iterative path. The cases are:
  - divisor = 0;
  - signed overflow;
  - either multiply operand = 0;
  - multiplier = 1 for MUL/MULW.
- `MDU_FAST_SPECIAL_EN` not defined: every operation takes the full N+2 latency.

## Test plan
- MUL, op1 = 3, op2 = 0xFFFF_FFFF_FFFF_FFFB (-5) → result 0xFFFF_FFFF_FFFF_FFF1; `valid_o_mdu` first high in cycle 66.
- DIV, op1 = -7, op2 = 2 → 0xFFFF_FFFF_FFFF_FFFD. REM with the same operands → 0xFFFF_FFFF_FFFF_FFFF. MULHU 0xFFFF_FFFF_FFFF_FFFF × itself → 0xFFFF_FFFF_FFFF_FFFE.
- Special cases:
  - DIVU 5/0 → all ones.
  - REM 7/0 → 7.
  - DIV 0x8000_0000_0000_0000 / -1 → 0x8000_0000_0000_0000.
  - REM with the same operands → 0.
  - Latency is 1 cycle if `MDU_FAST_SPECIAL_EN` is defined, else 66.
- DIVW, op1 = 0x0000_0001_8000_0000, op2 = 1 → 0xFFFF_FFFF_8000_0000 in cycle 34. MULW 0x7FFF_FFFF × 2 → 0xFFFF_FFFF_FFFF_FFFE.
- Backpressure: hold `ready_i_mdu` = 0 for 5 cycles after `valid_o_mdu` rises → result stable and `ready_o_mdu` = 0 throughout. Raising `ready_i_mdu` → IDLE next cycle, and a new accept is possible one cycle later.
- Abort and reset:
  - Assert `flush_i_mdu` in cycle 20 of a DIV → IDLE next cycle; `valid_o_mdu` never rises.
  - Assert `rst` in cycle 40 → outputs read 1/0/0 (`ready_o_mdu`/`valid_o_mdu`/`result_o_mdu`) next cycle.
  - Following MUL 6×7 → 42.

Source files
------------

// File: rtl/mdu_if.sv
// -----------------------------------------------------------------------------
// mdu_if : request/response bundle between the execute stage and the mdu.
//
// Signals
//   valid_i_mdu   request valid          (execute stage -> mdu)
//   ready_o_mdu   request ready          (mdu -> execute stage)
//   mdop_i_mdu    opcode [2:0]           (execute stage -> mdu)
//   word_i_mdu    W-form select          (execute stage -> mdu)
//   op1_i_mdu     rs1 / dividend / multiplicand
//   op2_i_mdu     rs2 / divisor / multiplier
//   flush_i_mdu   abort operation in flight
//   valid_o_mdu   result valid           (mdu -> consumer)
//   ready_i_mdu   consumer ready         (consumer -> mdu)
//   result_o_mdu  result                 (mdu -> consumer)
//
// Modports: master = execute stage / consumer side, slave = mdu.
// -----------------------------------------------------------------------------
interface mdu_if #(
   parameter int XLEN = 64
);
   logic            valid_i_mdu;
   logic            ready_o_mdu;
   logic [2:0]      mdop_i_mdu;
   logic            word_i_mdu;
   logic [XLEN-1:0] op1_i_mdu;
   logic [XLEN-1:0] op2_i_mdu;
   logic            flush_i_mdu;
   logic            valid_o_mdu;
   logic            ready_i_mdu;
   logic [XLEN-1:0] result_o_mdu;

   modport master (
      output valid_i_mdu, mdop_i_mdu, word_i_mdu, op1_i_mdu, op2_i_mdu,
             flush_i_mdu, ready_i_mdu,
      input  ready_o_mdu, valid_o_mdu, result_o_mdu
   );

   modport slave (
      input  valid_i_mdu, mdop_i_mdu, word_i_mdu, op1_i_mdu, op2_i_mdu,
             flush_i_mdu, ready_i_mdu,
      output ready_o_mdu, valid_o_mdu, result_o_mdu
   );
endinterface

// File: rtl/mdu.sv
// -----------------------------------------------------------------------------
// mdu : multi-cycle RV64 M-extension multiply/divide unit.
//
// Radix-2 shift-add multiplication and restoring division on operand
// magnitudes, one bit per cycle, followed by a one-cycle sign-fix step.
// FSM: IDLE -> CALC (N cycles) -> FIX (1 cycle) -> DONE (until ready_i_mdu).
// N = 64 for full-width ops, 32 for W forms (result sign-extended from bit 31).
//
// Ports
//   clk   core clock, rising edge
//   rst   synchronous active-high reset
//   bus   mdu_if.slave : valid/ready request, valid/ready response, flush
//
// Configuration macro
//   MDU_FAST_SPECIAL_EN : when defined, divide-by-zero, signed overflow,
//   multiply by zero and MUL/MULW by one finish IDLE -> DONE at accept.
// -----------------------------------------------------------------------------
module mdu #(
   parameter int XLEN = 64
) (
   input logic  clk,
   input logic  rst,
   mdu_if.slave bus
);

   localparam int W  = 32;
   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX,
      S_DONE
   } state_e;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } mdop_e;

   // ---------------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------------
   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q;
   mdop_e             op_q;
   logic              word_q;
   logic              neg_q_q;     // negate product / quotient
   logic              neg_r_q;     // negate remainder
   logic              dz_q;        // divisor was zero
   logic [XLEN-1:0]   b_q;         // multiplicand or divisor magnitude
   logic [2*XLEN-1:0] acc_q;       // mul: {hi, multiplier}; div: {rem, dividend/quotient}
   logic [XLEN-1:0]   result_q;

   // ---------------------------------------------------------------------------
   // Request decode and operand preparation
   // ---------------------------------------------------------------------------
   mdop_e           op_in;
   logic            accept;
   logic            is_div;
   logic            op1_signed, op2_signed;
   logic            sign1, sign2;
   logic [XLEN-1:0] op1_t, op2_t;
   logic [XLEN-1:0] mag1, mag2;
   logic [W-1:0]    neg1_w, neg2_w;

   assign op_in  = mdop_e'(bus.mdop_i_mdu);
   assign accept = bus.valid_i_mdu & (state_q == S_IDLE) & ~bus.flush_i_mdu;
   assign neg1_w = -bus.op1_i_mdu[W-1:0];
   assign neg2_w = -bus.op2_i_mdu[W-1:0];

   // NOTE: every signal driven in an always_comb gets a default first, so no
   // path through the block leaves it unassigned and no latch is inferred.
   always_comb begin
      is_div     = bus.mdop_i_mdu[2];
      op1_signed = (op_in == OP_DIV) || (op_in == OP_REM) ||
                   (op_in == OP_MULH) || (op_in == OP_MULHSU);
      op2_signed = (op_in == OP_DIV) || (op_in == OP_REM) || (op_in == OP_MULH);

      sign1 = op1_signed & (bus.word_i_mdu ? bus.op1_i_mdu[W-1] : bus.op1_i_mdu[XLEN-1]);
      sign2 = op2_signed & (bus.word_i_mdu ? bus.op2_i_mdu[W-1] : bus.op2_i_mdu[XLEN-1]);

      op1_t = bus.word_i_mdu ? {{(XLEN-W){1'b0}}, bus.op1_i_mdu[W-1:0]} : bus.op1_i_mdu;
      op2_t = bus.word_i_mdu ? {{(XLEN-W){1'b0}}, bus.op2_i_mdu[W-1:0]} : bus.op2_i_mdu;

      mag1 = op1_t;
      if (sign1) begin
         mag1 = bus.word_i_mdu ? {{(XLEN-W){1'b0}}, neg1_w} : -bus.op1_i_mdu;
      end
      mag2 = op2_t;
      if (sign2) begin
         mag2 = bus.word_i_mdu ? {{(XLEN-W){1'b0}}, neg2_w} : -bus.op2_i_mdu;
      end
   end

   // ---------------------------------------------------------------------------
   // Early-out detection for trivial operands
   // ---------------------------------------------------------------------------
   logic            fast_hit;
   logic [XLEN-1:0] fast_res;

`ifdef MDU_FAST_SPECIAL_EN
   logic            f_div0, f_ovf, f_mul0, f_mul1;
   logic [XLEN-1:0] min_n, ones_n, fast_raw;

   always_comb begin
      min_n  = bus.word_i_mdu ? {{(XLEN-W){1'b0}}, 1'b1, {(W-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
      ones_n = bus.word_i_mdu ? {{(XLEN-W){1'b0}}, {W{1'b1}}} : {XLEN{1'b1}};

      f_div0 = is_div & (op2_t == '0);
      f_ovf  = is_div & op1_signed & (op1_t == min_n) & (op2_t == ones_n);
      f_mul0 = ~is_div & ((op1_t == '0) | (op2_t == '0));
      f_mul1 = (op_in == OP_MUL) & (op2_t == {{(XLEN-1){1'b0}}, 1'b1});

      fast_raw = '0;
      if (f_div0) begin
         // Quotient is all ones, remainder is the dividend.
         fast_raw = bus.mdop_i_mdu[1] ? op1_t : {XLEN{1'b1}};
      end else if (f_ovf) begin
         // Quotient is the dividend, remainder is zero.
         fast_raw = bus.mdop_i_mdu[1] ? '0 : op1_t;
      end else if (f_mul1) begin
         fast_raw = op1_t;
      end

      fast_hit = f_div0 | f_ovf | f_mul0 | f_mul1;
      fast_res = bus.word_i_mdu ? {{(XLEN-W){fast_raw[W-1]}}, fast_raw[W-1:0]} : fast_raw;
   end
`else
   assign fast_hit = 1'b0;
   assign fast_res = '0;
`endif

   // ---------------------------------------------------------------------------
   // One iteration of the CALC loop
   // ---------------------------------------------------------------------------
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_rsh;
   logic [XLEN:0]     div_diff;
   logic [2*XLEN-1:0] acc_step;

   always_comb begin
      mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
      // Partial remainder shifted left with the next dividend bit appended.
      div_rsh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      div_diff = div_rsh - {1'b0, b_q};

      if (op_q[2]) begin
         if (div_rsh >= {1'b0, b_q}) begin
            acc_step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
         end else begin
            acc_step = {div_rsh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
         end
      end else begin
         // Add-then-shift: carry out of the add becomes the new top bit.
         acc_step = {mul_sum, acc_q[XLEN-1:1]};
      end
   end

   // ---------------------------------------------------------------------------
   // Sign fix and result selection
   // ---------------------------------------------------------------------------
   logic [2*XLEN-1:0] prod, prod_s;
   logic [XLEN-1:0]   quo_s, rem_s, fix_raw, fix_res;

   always_comb begin
      // A 32-step multiply leaves the product 32 bits above its final place.
      prod   = word_q ? (acc_q >> W) : acc_q;
      prod_s = neg_q_q ? -prod : prod;
      quo_s  = (neg_q_q & ~dz_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      rem_s  = neg_r_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

      unique case (op_q)
         OP_MUL:                       fix_raw = prod_s[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fix_raw = prod_s[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              fix_raw = quo_s;
         default:                      fix_raw = rem_s;
      endcase

      fix_res = word_q ? {{(XLEN-W){fix_raw[W-1]}}, fix_raw[W-1:0]} : fix_raw;
   end

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of process ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next-state logic (flush wins over accept and completion)
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      if (bus.flush_i_mdu) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: if (accept) state_d = fast_hit ? S_DONE : S_CALC;
            S_CALC: if (cnt_q == '0) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: if (bus.ready_i_mdu) state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs, decoded from registered state only
   // ---------------------------------------------------------------------------
   always_comb begin
      bus.ready_o_mdu = (state_q == S_IDLE);
      bus.valid_o_mdu = (state_q == S_DONE);
   end

   assign bus.result_o_mdu = result_q;

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         op_q     <= OP_MUL;
         word_q   <= 1'b0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         dz_q     <= 1'b0;
         b_q      <= '0;
         acc_q    <= '0;
         result_q <= '0;
      end else if (accept) begin
         cnt_q   <= bus.word_i_mdu ? CW'(W - 1) : CW'(XLEN - 1);
         op_q    <= op_in;
         word_q  <= bus.word_i_mdu;
         neg_q_q <= sign1 ^ sign2;
         neg_r_q <= sign1;
         dz_q    <= (op2_t == '0);
         if (is_div) begin
            b_q   <= mag2;
            // Left-align a 32-bit dividend so the shift-out bit is always the MSB.
            acc_q <= {{XLEN{1'b0}},
                      bus.word_i_mdu ? {mag1[W-1:0], {(XLEN-W){1'b0}}} : mag1};
         end else begin
            b_q   <= mag1;
            acc_q <= {{XLEN{1'b0}}, mag2};
         end
         if (fast_hit) begin
            result_q <= fast_res;
         end
      end else if (state_q == S_CALC && !bus.flush_i_mdu) begin
         acc_q <= acc_step;
         cnt_q <= cnt_q - 1'b1;
      end else if (state_q == S_FIX && !bus.flush_i_mdu) begin
         result_q <= fix_res;
      end
   end

endmodule

// File: tb/tb_mdu.sv
// -----------------------------------------------------------------------------
// tb_mdu : directed self-checking bench for mdu.
// Each vector carries a hand-computed result and expected latency.
// -----------------------------------------------------------------------------
module tb_mdu;

   localparam logic [2:0] MUL    = 3'b000;
   localparam logic [2:0] MULH   = 3'b001;
   localparam logic [2:0] MULHSU = 3'b010;
   localparam logic [2:0] MULHU  = 3'b011;
   localparam logic [2:0] DIV    = 3'b100;
   localparam logic [2:0] DIVU   = 3'b101;
   localparam logic [2:0] REM    = 3'b110;
   localparam logic [2:0] REMU   = 3'b111;

   localparam int LAT64 = 66;
   localparam int LAT32 = 34;
`ifdef MDU_FAST_SPECIAL_EN
   localparam int LATSP = 1;
`else
   localparam int LATSP = 66;
`endif

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   mdu_if #(.XLEN(64)) bus ();

   mdu #(.XLEN(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request from IDLE with ready_i_mdu high, check latency and result.
   task automatic run_op(input string tag, input logic [2:0] op, input logic word,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp, input int exp_lat);
      int lat;
      bit seen;
      bus.mdop_i_mdu  = op;
      bus.word_i_mdu  = word;
      bus.op1_i_mdu   = a;
      bus.op2_i_mdu   = b;
      bus.valid_i_mdu = 1'b1;
      tick();
      bus.valid_i_mdu = 1'b0;
      lat  = 1;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (bus.valid_o_mdu) begin
            seen = 1'b1;
            break;
         end
         tick();
         lat++;
      end
      if (!seen) begin
         check({tag, "_timeout"}, 64'(bus.valid_o_mdu), 64'd1);
      end else begin
         check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
         check(tag, bus.result_o_mdu, exp);
      end
      tick();
   endtask

   initial begin
      int seen_valid;
      bit got_valid;
      n_cmp = 0;
      n_err = 0;
      rst                 = 1'b1;
      bus.valid_i_mdu     = 1'b0;
      bus.mdop_i_mdu      = 3'b000;
      bus.word_i_mdu      = 1'b0;
      bus.op1_i_mdu       = '0;
      bus.op2_i_mdu       = '0;
      bus.flush_i_mdu     = 1'b0;
      bus.ready_i_mdu     = 1'b1;
      repeat (3) tick();
      rst = 1'b0;

      check("rst_ready",  64'(bus.ready_o_mdu), 64'd1);
      check("rst_valid",  64'(bus.valid_o_mdu), 64'd0);
      check("rst_result", bus.result_o_mdu,     64'd0);

      // Main function
      run_op("mul_3_m5",   MUL,    1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, LAT64);
      run_op("div_m7_2",   DIV,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, LAT64);
      run_op("rem_m7_2",   REM,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, LAT64);
      run_op("mulhu_ones", MULHU,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, LAT64);
      run_op("mulh_m1_m1", MULH,   1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, LAT64);
      run_op("mulhsu_m1_2", MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, LAT64);
      run_op("remu_100_7", REMU,   1'b0, 64'd100, 64'd7, 64'd2, LAT64);

      // Division special cases
      run_op("divu_5_0",   DIVU,   1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, LATSP);
      run_op("rem_7_0",    REM,    1'b0, 64'd7, 64'd0, 64'd7, LATSP);
      run_op("div_ovf",    DIV,    1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, LATSP);
      run_op("rem_ovf",    REM,    1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, LATSP);

      // W forms
      run_op("divw",       DIV,    1'b1, 64'h0000_0001_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, LAT32);
      run_op("mulw",       MUL,    1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, LAT32);
      run_op("divuw",      DIVU,   1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, LAT32);

      // Backpressure: DONE held for 5 cycles with ready_i_mdu low
      bus.ready_i_mdu = 1'b0;
      bus.mdop_i_mdu  = DIV;
      bus.word_i_mdu  = 1'b0;
      bus.op1_i_mdu   = 64'd100;
      bus.op2_i_mdu   = 64'd7;
      bus.valid_i_mdu = 1'b1;
      tick();
      bus.valid_i_mdu = 1'b0;
      got_valid = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (bus.valid_o_mdu) begin
            got_valid = 1'b1;
            break;
         end
         tick();
      end
      check("bp_valid_rise", 64'(got_valid), 64'd1);
      for (int i = 0; i < 5; i++) begin
         check("bp_result", bus.result_o_mdu, 64'd14);
         check("bp_ready",  64'(bus.ready_o_mdu), 64'd0);
         check("bp_valid",  64'(bus.valid_o_mdu), 64'd1);
         tick();
      end
      bus.ready_i_mdu = 1'b1;
      tick();
      check("bp_idle_ready", 64'(bus.ready_o_mdu), 64'd1);
      check("bp_idle_valid", 64'(bus.valid_o_mdu), 64'd0);
      run_op("after_bp", MUL, 1'b0, 64'd11, 64'd13, 64'd143, LAT64);

      // Flush in cycle 20 of a DIV
      bus.mdop_i_mdu  = DIV;
      bus.op1_i_mdu   = 64'd100;
      bus.op2_i_mdu   = 64'd3;
      bus.valid_i_mdu = 1'b1;
      tick();
      bus.valid_i_mdu = 1'b0;
      repeat (19) tick();
      bus.flush_i_mdu = 1'b1;
      tick();
      bus.flush_i_mdu = 1'b0;
      check("flush_idle", 64'(bus.ready_o_mdu), 64'd1);
      seen_valid = 0;
      for (int i = 0; i < 80; i++) begin
         if (bus.valid_o_mdu) seen_valid++;
         tick();
      end
      check("flush_no_valid", 64'(seen_valid), 64'd0);

      // Reset in cycle 40 of a MUL
      bus.mdop_i_mdu  = MUL;
      bus.op1_i_mdu   = 64'd5;
      bus.op2_i_mdu   = 64'd9;
      bus.valid_i_mdu = 1'b1;
      tick();
      bus.valid_i_mdu = 1'b0;
      repeat (39) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_ready",  64'(bus.ready_o_mdu), 64'd1);
      check("mid_rst_valid",  64'(bus.valid_o_mdu), 64'd0);
      check("mid_rst_result", bus.result_o_mdu,     64'd0);
      run_op("mul_6_7", MUL, 1'b0, 64'd6, 64'd7, 64'd42, LAT64);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
